// File: rtl/freq_word_loader.sv
// freq_word_loader: parses HEADER,W2,W1,W0,CHK byte frames from a UART
// stream and atomically loads the 24-bit DDS frequency word.
module freq_word_loader #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [23:0] RESET_WORD  = 24'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [23:0] f_word,
  output logic        word_upd,
  output logic        frame_err
);

  localparam int unsigned CW =
    (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  // The timeout fires on the edge where the idle count
  // would step onto TIMEOUT_CYC-1, i.e. while it holds
  // TIMEOUT_CYC-2.
  localparam int unsigned LIM_I =
    (TIMEOUT_CYC >= 2) ? TIMEOUT_CYC - 2 : 0;
  localparam logic [CW-1:0] LIM    = CW'(LIM_I);
  localparam bit            TMO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B2,
    S_B1,
    S_B0,
    S_CHK,
    S_COMMIT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [23:0]   shadow;
  logic [23:0]   shadow_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          load;
  logic          err;
  logic          accept;
  logic          in_frame;
  logic          chk_ok;
  logic          tmo;

  assign rx_ready = (state != S_COMMIT);
  assign accept   = rx_valid & rx_ready;
  assign in_frame = (state == S_B2) || (state == S_B1) ||
                    (state == S_B0) || (state == S_CHK);
  assign chk_ok   = rx_data ==
                    (shadow[23:16] ^ shadow[15:8] ^ shadow[7:0]);
  assign tmo      = TMO_EN && in_frame && !accept &&
                    (cnt >= LIM);

  // Next-state, shadow capture, idle counter and event strobes.
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    cnt_n    = cnt;
    load     = 1'b0;
    err      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (accept && rx_data == HEADER) begin
          state_n = S_B2;
        end
      end
      S_B2: begin
        if (accept) begin
          shadow_n[23:16] = rx_data;
          state_n         = S_B1;
        end
      end
      S_B1: begin
        if (accept) begin
          shadow_n[15:8] = rx_data;
          state_n        = S_B0;
        end
      end
      S_B0: begin
        if (accept) begin
          shadow_n[7:0] = rx_data;
          state_n       = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (chk_ok) begin
            load    = 1'b1;
            state_n = S_COMMIT;
          end else begin
            err      = 1'b1;
            shadow_n = '0;
            state_n  = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (!in_frame || accept) begin
      cnt_n = '0;
    end else if (tmo) begin
      cnt_n    = '0;
      err      = 1'b1;
      shadow_n = '0;
      state_n  = S_IDLE;
    end else if (cnt != '1) begin
      cnt_n = cnt + 1'b1;
    end
  end

  // State, shadow and idle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      shadow <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      shadow <= shadow_n;
      cnt    <= cnt_n;
    end
  end

  // Output word loads all 24 bits at once; strobes last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_word    <= RESET_WORD;
      word_upd  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load) begin
        f_word <= shadow;
      end
      word_upd  <= load;
      frame_err <= err;
    end
  end

endmodule

// File: tb/tb_freq_word_loader.sv
// tb_freq_word_loader: scoreboard bench for freq_word_loader.
// Frame-level reference model predicts word loads and dropped frames.
module tb_freq_word_loader;

  localparam logic [7:0]  HDR   = 8'hA5;
  localparam int          TMO   = 10;
  localparam logic [23:0] RST_W = 24'h5A5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [23:0] f_word;
  logic        word_upd;
  logic        frame_err;

  freq_word_loader #(
    .HEADER      (HDR),
    .TIMEOUT_CYC (TMO),
    .RESET_WORD  (RST_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .f_word    (f_word),
    .word_upd  (word_upd),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [23:0] w;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          checks = 0;
  int          errors = 0;

  bit          m_active;
  logic [7:0]  m_buf[$];
  logic [23:0] m_fw;

  // Reference: frame-level parse of one byte preceded by gap idle cycles.
  task automatic model_byte(input logic [7:0] b, input int gap);
    logic [23:0] w;
    if (m_active && gap >= TMO - 1) begin
      exp_q.push_back('{1'b1, m_fw});
      m_active = 0;
      m_buf.delete();
    end
    if (!m_active) begin
      if (b == HDR) m_active = 1;
    end else if (m_buf.size() < 3) begin
      m_buf.push_back(b);
    end else begin
      w = {m_buf[0], m_buf[1], m_buf[2]};
      if (b == (m_buf[0] ^ m_buf[1] ^ m_buf[2])) begin
        m_fw = w;
        exp_q.push_back('{1'b0, w});
      end else begin
        exp_q.push_back('{1'b1, m_fw});
      end
      m_active = 0;
      m_buf.delete();
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit acc;
    model_byte(b, gap);
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    acc      = 0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout byte=%h rx_ready stayed 0", b);
    end
  endtask

  task automatic send_frame(input logic [23:0] w, input logic [7:0] c);
    send(HDR, 0);
    send(w[23:16], 0);
    send(w[15:8], 0);
    send(w[7:0], 0);
    send(c, 0);
  endtask

  function automatic logic [7:0] xsum(input logic [23:0] w);
    return w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  function automatic int rgap();
    int r;
    int longs[5] = '{7, 8, 9, 10, 12};
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 17) return $urandom_range(1, 4);
    return longs[$urandom_range(0, 4)];
  endfunction

  task automatic drain(input string tag);
    if (m_active) begin
      exp_q.push_back('{1'b1, m_fw});
      m_active = 0;
      m_buf.delete();
    end
    rx_valid = 1'b0;
    repeat (TMO + 6) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (f_word !== RST_W) begin
      errors++;
      $display("FAIL %s_f_word got=%h exp=%h", tag, f_word, RST_W);
    end
    checks++;
    if (word_upd !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_strobes got=%b%b exp=00", tag, word_upd, frame_err);
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_rx_ready got=%b exp=1", tag, rx_ready);
    end
  endtask

  // Monitor: every strobe must match the next predicted event.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (word_upd && frame_err) begin
        checks++;
        errors++;
        $display("FAIL both_strobes word_upd=1 frame_err=1 exp one");
      end else if (word_upd || frame_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event upd=%b err=%b f_word=%h exp none",
                   word_upd, frame_err, f_word);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.err !== frame_err || mon_e.w !== f_word) begin
            errors++;
            $display("FAIL event got err=%b f_word=%h exp err=%b f_word=%h",
                     frame_err, f_word, mon_e.err, mon_e.w);
          end
        end
        if (word_upd) begin
          checks++;
          if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_ready got=%b exp=0", rx_ready);
          end
        end
      end
    end
  end

  initial begin
    logic [23:0] w;
    logic [7:0]  c;
    int          k;
    int          n;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    m_active = 0;
    m_fw     = RST_W;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_frame(24'h123456, 8'h70);
    send_frame(24'h123456, 8'h71);
    send(8'h00, 0);
    send(8'hFF, 0);
    send_frame(24'h000001, 8'h01);
    drain("directed_a");

    send(HDR, 0);
    send(8'h12, 0);
    send(HDR, 9);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h02, 0);
    send(HDR, 0);
    send(8'h12, 0);
    send(8'h34, 8);
    send(8'h56, 0);
    send(8'h70, 0);
    send_frame({HDR, HDR, HDR}, HDR);
    drain("directed_b");

    for (int f = 0; f < 200; f++) begin
      k = $urandom_range(0, 9);
      w = 24'($urandom);
      if (k == 9) w[15:8] = HDR;
      c = xsum(w);
      if (k == 5) c = c ^ 8'($urandom_range(1, 255));
      if (k == 6 || k == 8) begin
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) send(8'($urandom), rgap());
      end else if (k == 7) begin
        send(HDR, rgap());
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) send(8'($urandom), 0);
        send(8'($urandom), 9 + $urandom_range(0, 3));
      end else begin
        send(HDR, rgap());
        send(w[23:16], rgap());
        send(w[15:8], rgap());
        send(w[7:0], rgap());
        send(c, rgap());
      end
    end
    drain("random");

    send(HDR, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    rst_n = 1'b0;
    m_active = 0;
    m_buf.delete();
    m_fw = RST_W;
    #2;
    check_reset_outputs("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(24'hABCDEF, 8'h89);
    drain("after_reset");

    checks++;
    if (f_word !== 24'hABCDEF) begin
      errors++;
      $display("FAIL final_f_word got=%h exp=abcdef", f_word);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_word_loader.md
FREQ_WORD_LOADER -- requirements
Module: freq_word_loader

Interface
REQ-001 Parameter HEADER, default 8'hA5, frame start byte.
REQ-002 Parameter TIMEOUT_CYC, default 50000, maximum idle cycles between bytes of one frame; 0 disables the timeout.
REQ-003 Parameter RESET_WORD, default 24'd0, value f_word takes in reset.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rx_data  input  8  byte from UART RX FIFO.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader can take a byte; a byte is accepted on an edge where rx_valid & rx_ready.
REQ-009 f_word  output  24  registered frequency word driven to the square-wave DDS.
REQ-010 word_upd  output  1  one-cycle pulse, f_word has just been loaded.
REQ-011 frame_err  output  1  one-cycle pulse, a frame was dropped.

Function
REQ-012 Frame format SHALL be: HEADER, W[23:16], W[15:8], W[7:0], CHK, with CHK = W[23:16] ^ W[15:8] ^ W[7:0].
REQ-013 FSM states SHALL be IDLE, B2, B1, B0, CHK, COMMIT; reset state IDLE.
REQ-014 IDLE: accepted byte == HEADER -> B2; any other accepted byte discarded silently, stay IDLE.
REQ-015 B2/B1/B0: accepted byte stored in a 24-bit shadow register at [23:16]/[15:8]/[7:0] respectively; advance B2->B1->B0->CHK.
REQ-016 Payload bytes equal to HEADER SHALL be treated as data (no resynchronisation).
REQ-017 CHK, accepted byte matches XOR: on that edge f_word <= shadow, word_upd <= 1, state -> COMMIT.
REQ-018 CHK, accepted byte mismatches: f_word unchanged, frame_err <= 1, state -> IDLE.
REQ-019 COMMIT SHALL last exactly one cycle with rx_ready = 0, then -> IDLE.
REQ-020 rx_ready SHALL be 1 in every state except COMMIT.
REQ-021 Latency: f_word and word_upd SHALL change on the edge accepting CHK (visible one cycle after CHK is presented); f_word SHALL update atomically, all 24 bits together.
REQ-022 Timeout counter SHALL clear on every accepted byte and in IDLE/COMMIT, and increment each cycle in B2/B1/B0/CHK with no accepted byte.
REQ-023 When the counter reaches TIMEOUT_CYC-1 with no byte accepted: state -> IDLE, frame_err <= 1, shadow discarded, f_word unchanged.
REQ-024 If a byte is accepted on the same edge the timeout would fire, the byte SHALL be processed and the timeout SHALL not fire.
REQ-025 word_upd and frame_err SHALL never assert together, and neither SHALL stay high for more than one cycle per event.
REQ-026 Counter width SHALL be wide enough for TIMEOUT_CYC and SHALL not wrap.

Reset
REQ-027 rst_n low SHALL force, asynchronously: state IDLE, f_word = RESET_WORD, shadow = 0, counter = 0, word_upd = 0, frame_err = 0. rx_ready is 1 because the state is IDLE.
REQ-028 Reset mid-frame SHALL discard the partial frame. The first byte after reset release SHALL be handled as in IDLE.

Verification
REQ-029 Bytes A5 12 34 56 70 back-to-back -> f_word = 24'h123456 and word_upd high for 1 cycle after the 70 byte; rx_ready low for that cycle.
REQ-030 Bytes A5 12 34 56 71 -> frame_err pulse for 1 cycle; f_word keeps its previous value; no word_upd.
REQ-031 Bytes 00 FF A5 00 00 01 01 -> the 00 and FF are dropped silently; then f_word = 24'h000001 with one word_upd.
REQ-032 TIMEOUT_CYC=10; A5 12, then idle for 9 cycles -> frame_err on the 9th idle cycle; the following bytes A5 00 00 02 02 load 24'h000002.
REQ-033 TIMEOUT_CYC=10; A5 12, then idle for 8 cycles, then 34 on the 9th cycle -> no frame_err; the frame continues normally.
REQ-034 rst_n pulsed low after A5 12 34 -> f_word = RESET_WORD, outputs cleared; a new frame A5 AB CD EF 89 loads 24'hABCDEF.
